bfis_query_driver: RTL
======================

BFIS_QUERY_DRIVER -- requirements
Module: bfis_query_driver

Interface
REQ-001 Parameter DIM, default 2: coordinates per query position.
REQ-002 Parameter K_MAX, default 5: number of top-k result slots returned by the search engine.
REQ-003 Parameter TIMEOUT, default 4096: maximum number of WAIT cycles before a search is abandoned.
REQ-004 clk_in  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_in  input  1  reset, asynchronous, active-high.
REQ-006 q_vertex_in  input  32  start vertex of the incoming query.
REQ-007 q_pos_in  input  32 x DIM  query coordinates.
REQ-008 q_k_in  input  16  requested result count.
REQ-009 q_valid_in / q_ready_out  input / output  1 / 1  query handshake; transfer when both are high.
REQ-010 pq_length_in  input  16  priority-queue length configuration; passed through to the engine.
REQ-011 vertex_out, vertex_valid_out  output  32, 1  start vertex to the search engine, with its strobe.
REQ-012 query_out  output  32 x DIM  coordinates to the search engine.
REQ-013 pq_length_out, k_out  output  16, 16  engine configuration.
REQ-014 top_k_in, search_valid_in  input  32 x K_MAX, 1  engine results and their completion strobe.
REQ-015 res_data_out, res_idx_out, res_last_out  output  32, 3, 1  result beat: vertex ID, slot index, last-beat flag.
REQ-016 res_valid_out / res_ready_in  output / input  1 / 1  result handshake; transfer when both are high.
REQ-017 busy_out, timeout_out, query_count_out  output  1, 1, 16  status: FSM not idle, one-cycle abandon pulse, completed-query count.

Function
REQ-018 FSM states SHALL be IDLE, LAUNCH, WAIT and DRAIN.
REQ-019 q_ready_out SHALL be high only in IDLE.
REQ-020 On an IDLE handshake the block SHALL register vertex, position and k_eff, where k_eff = min(q_k_in, K_MAX).
REQ-021 On an IDLE handshake with k_eff != 0 the FSM SHALL go to LAUNCH.
REQ-022 On an IDLE handshake with k_eff == 0 the FSM SHALL stay in IDLE, increment query_count_out and emit no beats.
REQ-023 In LAUNCH, vertex_valid_out SHALL be high for exactly one cycle, then the FSM SHALL go to WAIT.
REQ-024 vertex_out, query_out and k_out (= k_eff) SHALL hold their registered values from LAUNCH until the FSM returns to IDLE.
REQ-025 pq_length_out SHALL be pq_length_in, registered every cycle.
REQ-026 The WAIT cycle counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-027 search_valid_in high in WAIT SHALL capture all top_k_in slots, clear the result index and go to DRAIN.
REQ-028 search_valid_in high and a counter value of TIMEOUT-1 in the same cycle SHALL be treated as capture.
REQ-029 search_valid_in outside WAIT SHALL be ignored, with no state or output change.
REQ-030 Counter reaching TIMEOUT-1 without search_valid_in SHALL pulse timeout_out for one cycle, return to IDLE and emit no beats.
REQ-031 A timeout SHALL NOT increment query_count_out.
REQ-032 In DRAIN, res_valid_out SHALL be high, with res_data_out = captured slot[idx] and res_idx_out = idx.
REQ-033 res_last_out SHALL be high when idx == k_eff-1.
REQ-034 On a DRAIN handshake that is not the last beat, idx SHALL increment.
REQ-035 On the last-beat handshake, the FSM SHALL return to IDLE and query_count_out SHALL increment.
REQ-036 While res_ready_in is low in DRAIN, all res_* outputs SHALL hold stable.
REQ-037 query_count_out SHALL wrap from 0xFFFF to 0x0000.
REQ-038 busy_out SHALL be high in every state except IDLE.
REQ-039 Latency: IDLE handshake at edge N gives vertex_valid_out high in cycle N+1; capture at edge M gives res_valid_out high in cycle M+1.

Reset
REQ-040 While rst_in is high, state SHALL be IDLE and every output, counter and capture register SHALL be 0.
REQ-041 This reset state SHALL take effect immediately, without waiting for a clock edge.
REQ-042 A reset asserted mid-search or mid-drain SHALL discard the query and leave query_count_out at 0.
REQ-043 On the first edge after rst_in deasserts, q_ready_out SHALL be high.

Verification
REQ-044 Query vertex=7, k=3; engine returns {11,22,33,44,55} 10 cycles later; res_ready_in=1 -> beats (11,0), (22,1), (33,2,last); count=1.
REQ-045 Query with k=9 -> k_out=5; five beats, last at idx 4.
REQ-046 Query with k=0 -> no vertex_valid_out, no beats, count increments, q_ready_out remains high.
REQ-047 TIMEOUT=16, engine silent -> timeout_out pulses in the 16th WAIT cycle; count unchanged; a late search_valid_in is ignored.
REQ-048 res_ready_in toggled randomly during drain -> no beat lost or duplicated, and data held stable while stalled.
REQ-049 rst_in asserted mid-DRAIN -> res_valid_out drops with no clock edge needed; next query runs normally.

Source files
------------

// File: rtl/bfis_query_driver.sv
// BFIS query driver: accepts one query, launches it into the search engine, then
// either streams the engine's top-k slots out one beat at a time or abandons on timeout.
// res_idx_out is 3 bits wide, so K_MAX must not exceed 8.

module bfis_slot_reg (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        load_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);
  logic [31:0] slot_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)      slot_q <= '0;
    else if (load_i) slot_q <= d_i;
  end

  assign q_o = slot_q;
endmodule

module bfis_query_driver #(
  parameter int DIM     = 2,
  parameter int K_MAX   = 5,
  parameter int TIMEOUT = 4096
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [31:0]                 q_vertex_in,
  input  logic [DIM-1:0][31:0]        q_pos_in,
  input  logic [15:0]                 q_k_in,
  input  logic                        q_valid_in,
  output logic                        q_ready_out,
  input  logic [15:0]                 pq_length_in,
  output logic [31:0]                 vertex_out,
  output logic                        vertex_valid_out,
  output logic [DIM-1:0][31:0]        query_out,
  output logic [15:0]                 pq_length_out,
  output logic [15:0]                 k_out,
  input  logic [K_MAX-1:0][31:0]      top_k_in,
  input  logic                        search_valid_in,
  output logic [31:0]                 res_data_out,
  output logic [2:0]                  res_idx_out,
  output logic                        res_last_out,
  output logic                        res_valid_out,
  input  logic                        res_ready_in,
  output logic                        busy_out,
  output logic                        timeout_out,
  output logic [15:0]                 query_count_out
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DRAIN} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [15:0]          qcnt_q, qcnt_d;
  logic [15:0]          pql_q;
  logic [31:0]          vtx_q;
  logic [DIM-1:0][31:0] pos_q;
  logic [15:0]          k_q;

  logic [K_MAX-1:0][31:0] slots;
  logic                   cap_en;
  logic                   q_hs;
  logic                   drain;
  logic                   last_beat;
  logic [15:0]            k_eff;
  logic [31:0]            slot_sel;

  assign k_eff = (q_k_in > 16'(K_MAX)) ? 16'(K_MAX) : q_k_in;
  // Gated by rst_in so every output reads 0 for the whole reset window.
  assign q_ready_out = (state_q == S_IDLE) && !rst_in;
  assign q_hs        = q_valid_in && q_ready_out;
  assign drain       = (state_q == S_DRAIN);
  assign last_beat   = ({13'b0, idx_q} == (k_q - 16'd1));

  for (genvar s = 0; s < K_MAX; s++) begin : g_slot
    bfis_slot_reg u_slot (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .load_i (cap_en),
      .d_i    (top_k_in[s]),
      .q_o    (slots[s])
    );
  end

  always_comb begin
    slot_sel = '0;
    for (int s = 0; s < K_MAX; s++)
      if (idx_q == 3'(s)) slot_sel = slots[s];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    qcnt_d      = qcnt_q;
    cap_en      = 1'b0;
    timeout_out = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (q_hs) begin
          // A zero-length query completes on the spot without touching the engine.
          if (k_eff == 16'd0) qcnt_d = qcnt_q + 16'd1;
          else                state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the final cycle still wins over the timeout.
        if (search_valid_in) begin
          cap_en  = 1'b1;
          idx_d   = '0;
          state_d = S_DRAIN;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_out = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (res_ready_in) begin
          if (last_beat) begin
            state_d = S_IDLE;
            qcnt_d  = qcnt_q + 16'd1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      qcnt_q  <= '0;
      pql_q   <= '0;
      vtx_q   <= '0;
      pos_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      qcnt_q  <= qcnt_d;
      pql_q   <= pq_length_in;
      if (q_hs) begin
        vtx_q <= q_vertex_in;
        pos_q <= q_pos_in;
        k_q   <= k_eff;
      end
    end
  end

  assign vertex_out       = vtx_q;
  assign query_out        = pos_q;
  assign k_out            = k_q;
  assign pq_length_out    = pql_q;
  assign vertex_valid_out = (state_q == S_LAUNCH);
  assign res_valid_out    = drain;
  assign res_data_out     = drain ? slot_sel : 32'd0;
  assign res_idx_out      = drain ? idx_q : 3'd0;
  assign res_last_out     = drain && last_beat;
  assign busy_out         = (state_q != S_IDLE);
  assign query_count_out  = qcnt_q;
endmodule
